// File: rtl/avalon_burst_responder.sv
// rtl/avalon_burst_responder.sv - Avalon-MM burst-read / single-write memory responder
//
// Stands in for the EMIF DRAM port. It models a word-addressed on-chip RAM
// with a read command FIFO, a burst sequencer and a fixed-latency return pipe.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   address           word address (taken modulo MEM_WORDS)
//   read, write       command strobes
//   writedata         write beat
//   burstcount        beats requested (1..MAX_BURST for reads, 1 for writes)
//   readdata          read beat (0 when readdatavalid is low)
//   waitrequest       command not accepted this cycle
//   readdatavalid     readdata carries a beat
//   beats_pending     read beats accepted but not yet returned
//   protocol_err      sticky illegal-command flag, cleared by reset
//
// Optional build macro RESP_RANDOM_STALL_EN: a 16-bit LFSR forces waitrequest
// high on roughly 1 cycle in 8 to exercise master retry logic.

module avalon_burst_responder #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 28,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 4,
    parameter int CMD_DEPTH    = 4,
    parameter int MAX_BURST    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    input  logic [6:0]            burstcount,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  waitrequest,
    output logic                  readdatavalid,
    output logic [15:0]           beats_pending,
    output logic                  protocol_err
);

    localparam int         MW     = $clog2(MEM_WORDS);
    localparam int         PW     = $clog2(CMD_DEPTH);
    localparam logic [6:0] MAX_BC = 7'(MAX_BURST);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic          stall;
    logic          fifo_full;
    logic          fifo_empty;
    logic          bc_ok;
    logic          wr_acc;
    logic          rd_push;
    logic          err_set;
    logic [MW-1:0] cmd_idx;
    logic          unused_addr_bits;

    assign cmd_idx          = address[MW-1:0];
    assign unused_addr_bits = ^address[ADDR_WIDTH-1:MW];

`ifdef RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    assign waitrequest = reset | fifo_full | stall;
    assign bc_ok       = (burstcount != 7'd0) && (burstcount <= MAX_BC);
    // A write always wins over a simultaneous read.
    assign wr_acc      = write & ~waitrequest;
    assign rd_push     = read & ~write & ~waitrequest & bc_ok;
    assign err_set     = (wr_acc & (burstcount != 7'd1))
                       | (read & write & ~waitrequest)
                       | (read & ~write & ~waitrequest & ~bc_ok);

    // ------------------------------------------------------------------
    // Read command FIFO
    // ------------------------------------------------------------------
    logic [MW-1:0] fifo_addr [CMD_DEPTH];
    logic [6:0]    fifo_len  [CMD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_count;
    logic          fifo_pop;

    assign fifo_full  = (fifo_count == (PW+1)'(CMD_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    always_ff @(posedge clk) begin
        if (rd_push) begin
            fifo_addr[wr_ptr] <= cmd_idx;
            fifo_len[wr_ptr]  <= burstcount;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (rd_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + (PW+1)'(rd_push) - (PW+1)'(fifo_pop);
        end
    end

    // ------------------------------------------------------------------
    // Burst sequencer
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_next;
    logic [MW-1:0] seq_addr;
    logic [6:0]    seq_remaining;
    logic          seq_last;
    logic          issue;

    assign seq_last = (seq_remaining == 7'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_next = S_BURST;
            S_BURST: if (seq_last && fifo_empty) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // On the last beat of a burst the next command is popped in the same
    // cycle so back-to-back bursts stream without a bubble.
    always_comb begin
        issue    = 1'b0;
        fifo_pop = 1'b0;
        case (state)
            S_IDLE: begin
                fifo_pop = !fifo_empty;
            end
            S_BURST: begin
                issue    = 1'b1;
                fifo_pop = seq_last && !fifo_empty;
            end
            default: begin
                issue    = 1'b0;
                fifo_pop = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_addr      <= '0;
            seq_remaining <= '0;
        end else if (fifo_pop) begin
            seq_addr      <= fifo_addr[rd_ptr];
            seq_remaining <= fifo_len[rd_ptr];
        end else if (issue) begin
            // MEM_WORDS is a power of two, so the increment wraps naturally.
            seq_addr      <= seq_addr + MW'(1);
            seq_remaining <= seq_remaining - 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // RAM and return pipeline
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0]   ram_q;
    logic [DATA_WIDTH-1:0]   pipe_out;
    logic [READ_LATENCY-1:0] valid_pipe;

    // Nonblocking write + registered read gives old data when a write and
    // an issued read hit the same word in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[cmd_idx] <= writedata;
        end
        ram_q <= mem[seq_addr];
    end

    generate
        if (READ_LATENCY > 1) begin : g_delay
            logic [DATA_WIDTH-1:0] dly [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                dly[0] <= ram_q;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    dly[i] <= dly[i-1];
                end
            end

            assign pipe_out = dly[READ_LATENCY-2];
        end else begin : g_nodelay
            assign pipe_out = ram_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= READ_LATENCY'({valid_pipe, issue});
        end
    end

    assign readdatavalid = valid_pipe[READ_LATENCY-1];
    // Data registers carry no reset; gating keeps readdata at zero when idle.
    assign readdata      = readdatavalid ? pipe_out : '0;

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            beats_pending <= '0;
        end else begin
            beats_pending <= beats_pending
                           + (rd_push ? 16'(burstcount) : 16'd0)
                           - 16'(readdatavalid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err <= 1'b0;
        end else if (err_set) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_avalon_burst_responder.sv
// tb/tb_avalon_burst_responder.sv - directed self-checking bench for avalon_burst_responder

module tb_avalon_burst_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic [27:0]  address;
    logic         read;
    logic         write;
    logic [511:0] writedata;
    logic [6:0]   burstcount;
    logic [511:0] readdata;
    logic         waitrequest;
    logic         readdatavalid;
    logic [15:0]  beats_pending;
    logic         protocol_err;

    int total = 0;
    int bad   = 0;
    int stalls = 0;
    int seen;
    logic [511:0] expq [$];

    avalon_burst_responder dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .burstcount    (burstcount),
        .readdata      (readdata),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .beats_pending (beats_pending),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a command at the falling edge and holds it until it will be
    // accepted at the next rising edge.
    task automatic cmd(input bit is_rd, input bit is_wr, input int addr,
                       input logic [511:0] data, input int bc);
        int t;
        @(negedge clk);
        read       = is_rd;
        write      = is_wr;
        address    = 28'(addr);
        writedata  = data;
        burstcount = 7'(bc);
        #1;
        t = 0;
        while (waitrequest && t < 100) begin
            stalls++;
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 100) chk("cmd_accept_timeout", 512'(waitrequest), 512'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Waits for the first beat, then requires every queued value on
    // consecutive cycles.
    task automatic drain(input string tag);
        int t;
        int n;
        n = expq.size();
        @(negedge clk);
        #1;
        t = 0;
        while (!readdatavalid && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 512'(readdatavalid), 512'd1);
            chk({tag, "_data"}, readdata, expq[i]);
            @(negedge clk);
            #1;
        end
        expq.delete();
    endtask

    initial begin
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        burstcount = 7'd1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_waitrequest", 512'(waitrequest), 512'd1);
        chk("rst_rdvalid", 512'(readdatavalid), 512'd0);
        chk("rst_readdata", readdata, 512'd0);
        chk("rst_pending", 512'(beats_pending), 512'd0);
        chk("rst_err", 512'(protocol_err), 512'd0);
        reset = 1'b0;

        // Single write then single read: accept A, pop A+1, issue A+2, data A+6
        cmd(0, 1, 5, 512'h1234, 1);
        cmd(1, 0, 5, 512'd0, 1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) begin
                read = 1'b0;
            end
            #1;
            if (i == 1) chk("t1_pending_after_accept", 512'(beats_pending), 512'd1);
            if (i < 6) chk("t1_no_early_valid", 512'(readdatavalid), 512'd0);
            if (i == 6) begin
                chk("t1_valid", 512'(readdatavalid), 512'd1);
                chk("t1_data", readdata, 512'h1234);
                chk("t1_pending_during", 512'(beats_pending), 512'd1);
            end
            if (i == 7) begin
                chk("t1_valid_drop", 512'(readdatavalid), 512'd0);
                chk("t1_pending_done", 512'(beats_pending), 512'd0);
            end
        end

        // Words 0..15 hold their index; two back-to-back bursts of 8
        for (int i = 0; i < 16; i++) cmd(0, 1, i, 512'(i), 1);
        cmd(1, 0, 0, 512'd0, 8);
        cmd(1, 0, 8, 512'd0, 8);
        idle();
        for (int i = 0; i < 16; i++) expq.push_back(512'(i));
        drain("t2");
        chk("t2_pending", 512'(beats_pending), 512'd0);

        // Wrap at the top of memory
        cmd(0, 1, 1022, 512'h3FE, 1);
        cmd(0, 1, 1023, 512'h3FF, 1);
        cmd(1, 0, 1022, 512'd0, 4);
        idle();
        expq.push_back(512'h3FE);
        expq.push_back(512'h3FF);
        expq.push_back(512'd0);
        expq.push_back(512'd1);
        drain("t3_wrap");

        // FIFO full: one command in the sequencer plus four queued
        for (int k = 0; k < 5; k++) begin
            cmd(1, 0, 0, 512'd0, 16);
            chk("t4_accepting", 512'(waitrequest), 512'd0);
        end
        @(negedge clk);
        read = 1'b0;
        #1;
        chk("t4_full_wait", 512'(waitrequest), 512'd1);
        chk("t4_pending80", 512'(beats_pending), 512'd80);
        for (int i = 0; i < 80; i++) expq.push_back(512'(i % 16));
        drain("t4");
        chk("t4_pending0", 512'(beats_pending), 512'd0);
        chk("t4_no_err", 512'(protocol_err), 512'd0);

        // Illegal commands, one at a time with a reset between
        cmd(1, 0, 0, 512'd0, 0);
        idle();
        #1;
        chk("t5_bc0_err", 512'(protocol_err), 512'd1);
        chk("t5_bc0_pending", 512'(beats_pending), 512'd0);
        pulse_reset();
        #1;
        chk("t5_err_cleared", 512'(protocol_err), 512'd0);
        cmd(1, 0, 0, 512'd0, 65);
        idle();
        #1;
        chk("t5_bc65_err", 512'(protocol_err), 512'd1);
        chk("t5_bc65_pending", 512'(beats_pending), 512'd0);
        pulse_reset();
        cmd(0, 1, 20, 512'hAB, 4);
        idle();
        #1;
        chk("t5_wrburst_err", 512'(protocol_err), 512'd1);
        pulse_reset();
        cmd(1, 1, 21, 512'hCD, 1);
        idle();
        #1;
        chk("t5_rw_err", 512'(protocol_err), 512'd1);
        chk("t5_rw_pending", 512'(beats_pending), 512'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (readdatavalid) seen++;
        end
        chk("t5_no_beats", 512'(seen), 512'd0);
        cmd(1, 0, 20, 512'd0, 2);
        idle();
        #1;
        chk("t5_sticky", 512'(protocol_err), 512'd1);
        expq.push_back(512'hAB);
        expq.push_back(512'hCD);
        drain("t5_readback");

        // Reset during the third beat of a 16-beat burst (issued at A+4)
        cmd(1, 0, 0, 512'd0, 16);
        idle();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_wait_in_reset", 512'(waitrequest), 512'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_valid_flushed", 512'(readdatavalid), 512'd0);
        chk("t6_readdata_zero", readdata, 512'd0);
        chk("t6_pending_zero", 512'(beats_pending), 512'd0);
        chk("t6_err_cleared", 512'(protocol_err), 512'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (readdatavalid) seen++;
        end
        chk("t6_no_beats_after", 512'(seen), 512'd0);
        cmd(1, 0, 20, 512'd0, 2);
        idle();
        expq.push_back(512'hAB);
        expq.push_back(512'hCD);
        drain("t6_ram_kept");

`ifdef RESP_RANDOM_STALL_EN
        stalls = 0;
        for (int i = 0; i < 256; i++) cmd(0, 1, 100 + i, 512'(i ^ 32'h5A5), 1);
        for (int k = 0; k < 4; k++) cmd(1, 0, 100 + 64 * k, 512'd0, 64);
        idle();
        for (int i = 0; i < 256; i++) expq.push_back(512'(i ^ 32'h5A5));
        drain("t7_stall");
        chk("t7_stalls_seen", 512'(stalls >= 10), 512'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/avalon_burst_responder.md
Name: avalon_burst_responder

Overview:
- Avalon-MM slave (responder) that models the EMIF side of the DRAM port: 512-bit word-addressed memory accepting single-beat writes and burst reads.
- Backed by on-chip RAM, with a command FIFO, a read-burst sequencer and a fixed read-latency pipeline.
- Sits opposite the matrix DRAM agent in simulation and FPGA loopback builds, in place of the real memory controller.

Parameters:
- DATA_WIDTH, 512, data word width in bits.
- ADDR_WIDTH, 28, word address width.
- MEM_WORDS, 1024, backing RAM depth, power of two; address used modulo MEM_WORDS.
- READ_LATENCY, 4, cycles from a beat being issued to RAM until it appears on readdata; legal range 1..16.
- CMD_DEPTH, 4, read command FIFO depth, power of two.
- MAX_BURST, 64, largest legal burstcount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_WIDTH  write data.
- burstcount  in  7  beats requested.
- readdata  out  DATA_WIDTH  read response data.
- waitrequest  out  1  command not accepted this cycle.
- readdatavalid  out  1  readdata valid this cycle.
- beats_pending  out  16  read beats accepted but not yet returned.
- protocol_err  out  1  sticky illegal-command flag.

Behaviour:
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, beats_pending=0, protocol_err=0. FIFO, sequencer and latency pipeline are flushed; RAM contents are retained.
- waitrequest is combinational: 1 when reset or command FIFO full; otherwise 0.
- Accept rule: a command is accepted when (read or write) and !waitrequest.
- Write:
  - Accepted write commits writedata to RAM[address mod MEM_WORDS] at the clock edge.
  - burstcount!=1 on a write: only that one beat is written, and protocol_err is set.
- Read:
  - Accepted read pushes {address, burstcount} into the command FIFO.
  - beats_pending += burstcount on accept; -1 on each readdatavalid. Same-cycle accept and return apply both.
- Illegal reads:
  - burstcount==0 or >MAX_BURST: command dropped, not queued, and protocol_err is set.
  - read and write both high: write performed, read ignored, protocol_err set.
- Sequencer FSM:
  - IDLE: if FIFO not empty, pop, load addr and remaining count, go to BURST.
  - BURST: issue one RAM read per cycle; addr increments and wraps at MEM_WORDS-1 -> 0; remaining decrements.
  - At the last beat: if FIFO is not empty, pop next and stay in BURST (no bubble); else go to IDLE.
- Latency and ordering:
  - Issued beat appears with readdatavalid exactly READ_LATENCY cycles later.
  - Returns are in command order with no gaps within a burst.
- Hazards:
  - A beat issued in cycle N returns RAM contents as of writes committed before N.
  - A same-cycle write to the issued address returns old data.
- Mid-operation reset drops all in-flight beats: readdatavalid=0 from the cycle after reset is sampled.
- protocol_err clears only on reset.

Optional Feature:
- Macro RESP_RANDOM_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - waitrequest is additionally forced to 1 whenever lfsr[2:0]==0 (~1/8 of cycles), to stress master retry logic.
  - Sequencer and return path are unaffected.
- Undefined: no LFSR is present and waitrequest follows FIFO-full only.

Test Plan:
- Write 32'h1234 (zero-extended) to addr 5, then read burst 1 at addr 5 -> readdatavalid exactly READ_LATENCY=4 cycles after the issue cycle, readdata=32'h1234, beats_pending 1->0.
- Fill words 0..15 with their index, issue read bursts of 8 at 0 and 8 at 8 back-to-back -> 16 consecutive valid beats 0..15, no gap between bursts.
- Read burst 4 at addr MEM_WORDS-2 -> data of words 1022, 1023, 0, 1.
- Issue 5 read commands with no returns consumed -> waitrequest=1 while FIFO holds 4. Illegal inputs: burstcount=0 read, write with burstcount=4, read and write together -> protocol_err=1 and stays set, no extra beats returned.
- Assert reset during the 3rd beat of a 16-beat burst -> readdatavalid=0 thereafter, beats_pending=0. A re-read of the written data returns the pre-reset RAM contents.
- With RESP_RANDOM_STALL_EN, stream 256 single writes then read back -> all data correct and waitrequest observed high at least 10 times.
